// File: rtl/alu_writeback.sv
// alu_writeback: write-back stage of the ALU datapath.
// Completed ALU results (one or two words, each tagged with a destination
// register) are queued in a small circular FIFO and then written, one word per
// accepted memory cycle, through a registered valid/ready write port.
// Dual-result ops write lo to rdst1 first, then hi to rdst2.
module alu_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_dual,
  input  logic [ADDR_W-1:0]          in_rdst1,
  input  logic [ADDR_W-1:0]          in_rdst2,
  input  logic [DATA_W-1:0]          in_lo,
  input  logic [DATA_W-1:0]          in_hi,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WR_LO = 2'd1;
  localparam logic [1:0] WR_HI = 2'd2;

  typedef struct packed {
    logic              dual;
    logic [ADDR_W-1:0] rdst1;
    logic [ADDR_W-1:0] rdst2;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
  } entry_t;

  entry_t          fifo [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [1:0]      state;
  logic            hold_dual;
  logic [ADDR_W-1:0] hold_rdst2;
  logic [DATA_W-1:0] hold_hi;
  logic            push;
  logic            pop;
  logic            done;

  // Full is judged on the registered count only: a pop this cycle never frees
  // a slot for a push in the same cycle.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign done     = mem_we && mem_ready;
  assign head     = fifo[rd_ptr];
  assign busy     = (state != IDLE) || (count != '0);

  // Decide when the FSM takes the FIFO head into the holding register.
  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = (count != '0);
      WR_LO:   pop = done && !hold_dual && (count != '0);
      WR_HI:   pop = done && (count != '0);
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage: written on accepted input, never cleared.
  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{dual: in_dual, rdst1: in_rdst1, rdst2: in_rdst2,
                                lo: in_lo, hi: in_hi};
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write FSM: registered memory request, held stable until mem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hold_dual  <= 1'b0;
      hold_rdst2 <= '0;
      hold_hi    <= '0;
    end else if (pop) begin
      // Start the lo write of the next entry (also back-to-back from WR_LO/WR_HI).
      state      <= WR_LO;
      mem_we     <= 1'b1;
      mem_addr   <= head.rdst1;
      mem_wdata  <= head.lo;
      hold_dual  <= head.dual;
      hold_rdst2 <= head.rdst2;
      hold_hi    <= head.hi;
    end else if (done) begin
      if (state == WR_LO && hold_dual) begin
        state     <= WR_HI;
        mem_addr  <= hold_rdst2;
        mem_wdata <= hold_hi;
      end else begin
        state  <= IDLE;
        mem_we <= 1'b0;
      end
    end else if (state != IDLE && state != WR_LO && state != WR_HI) begin
      state  <= IDLE;
      mem_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: self-checking bench for alu_writeback.
// A queue of expected (addr, data) writes is built from every accepted input
// (lo write, then hi write for dual ops) and consumed by each completed
// memory write; directed phases add hand-computed expectations.
module tb_alu_writeback;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_dual;
  logic [ADDR_W-1:0] in_rdst1;
  logic [ADDR_W-1:0] in_rdst2;
  logic [DATA_W-1:0] in_lo;
  logic [DATA_W-1:0] in_hi;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic [CW-1:0]     count;

  alu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dual(in_dual),
    .in_rdst1(in_rdst1), .in_rdst2(in_rdst2), .in_lo(in_lo), .in_hi(in_hi),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  n_writes = 0;
  bit  chk_en = 0;
  bit  cnt_lim = 0;
  bit  prev_stall = 0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the queue model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      wr_t e;
      check("busy", busy, (q.size() != 0));
      check("in_ready", in_ready, (count != CW'(DEPTH)));
      if (cnt_lim) check("count_le_2", (count <= 2), 1);
      if (prev_stall)
        check("stall_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, prev_addr, prev_data});
      if (mem_we && mem_ready) begin
        n_writes++;
        if (q.size() == 0) begin
          check("spurious_write", 1, 0);
        end else begin
          e = q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
        end
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
      if (in_valid && in_ready) begin
        q.push_back('{addr: in_rdst1, data: in_lo});
        if (in_dual) q.push_back('{addr: in_rdst2, data: in_hi});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one result and hold it until accepted (bounded); returns at edge+1.
  task automatic push(input logic d, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [15:0] lo, input logic [15:0] hi);
    bit acc;
    int n;
    in_valid = 1'b1; in_dual = d; in_rdst1 = r1; in_rdst2 = r2; in_lo = lo; in_hi = hi;
    acc = 0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle_in();
    mem_ready = 1'b1;
    while ((q.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    check("drain_empty", q.size(), 0);
    check("drain_not_busy", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d [5];
    int n0;
    logic [3:0] pat;
    rst_n = 1'b0; in_valid = 0; in_dual = 0; in_rdst1 = 0; in_rdst2 = 0;
    in_lo = 0; in_hi = 0; mem_ready = 1'b1;
    #12;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    tick();
    rst_n = 1'b1;
    chk_en = 1;
    tick();

    // Single write: visible one edge after acceptance, gone one edge later.
    push(0, 5'd5, 5'd0, 16'h1234, 16'h0);
    idle_in();
    check("single_not_yet", mem_we, 0);
    tick();
    check("single_we", mem_we, 1);
    check("single_addr", mem_addr, 5);
    check("single_data", mem_wdata, 16'h1234);
    tick();
    check("single_we_drop", mem_we, 0);
    check("single_busy", busy, 0);

    // Dual write: (2,00FF) then (3,AB00) on consecutive cycles.
    push(1, 5'd2, 5'd3, 16'h00FF, 16'hAB00);
    idle_in();
    tick();
    check("dual_lo", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd2, 16'h00FF});
    tick();
    check("dual_hi", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd3, 16'hAB00});
    tick();
    check("dual_end", mem_we, 0);

    // Backpressure: five pushes with memory stalled fill one holding slot + FIFO.
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d[i] = 16'h1000 + 16'(i);
      push(0, 5'(10 + i), 5'd0, d[i], 16'h0);
    end
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 4);
    in_valid = 1'b1; in_dual = 0; in_rdst1 = 5'd31; in_lo = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_reject", in_ready, 0);
    end
    idle_in();
    mem_ready = 1'b1;
    check("bp_w0", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd10, d[0]});
    for (int i = 1; i < 5; i++) begin
      tick();
      check("bp_wn", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'(10 + i), d[i]});
    end
    tick();
    check("bp_end", mem_we, 0);

    // Stall hold during a dual write to the same register: hi lands last.
    push(1, 5'd7, 5'd7, 16'hAAAA, 16'h5555);
    idle_in();
    mem_ready = 1'b0;
    tick();
    check("stall_lo", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd7, 16'hAAAA});
    n0 = n_writes;
    pat = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      mem_ready = pat[i];
      tick();
      if (i == 2) check("stall_hi", {mem_we, mem_wdata}, {1'b1, 16'h5555});
    end
    mem_ready = 1'b0;
    tick();
    check("stall_two_writes", n_writes - n0, 2);
    check("stall_end", mem_we, 0);

    // Reset mid-run with three entries queued and a write pending.
    for (int i = 0; i < 4; i++) push(0, 5'(20 + i), 5'd0, 16'h2000 + 16'(i), 16'h0);
    idle_in();
    check("pre_rst_we", mem_we, 1);
    check("pre_rst_count", count, 3);
    #2;
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    check("midrst_we_async", mem_we, 0);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    prev_stall = 0;
    mem_ready = 1'b1;
    tick();
    #3;
    rst_n = 1'b1;
    tick();
    chk_en = 1;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_no_write", mem_we, 0);

    // Mixed stream: dual, single, gap — balanced against memory bandwidth.
    cnt_lim = 1;
    for (int g = 0; g < 8; g++) begin
      push(1, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
      push(0, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
      idle_in();
      tick();
    end
    drain();
    cnt_lim = 0;

    // Random traffic with random memory backpressure.
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit acc;
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_dual  = 1'($urandom);
        in_rdst1 = 5'($urandom);
        in_rdst2 = 5'($urandom);
        in_lo    = 16'($urandom);
        in_hi    = 16'($urandom);
      end
      mem_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    tick();
    drain();
    check("final_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
